// File: rtl/alu_xor_array_if.sv
// alu_xor_array_if: operand/result bundle with valid/ready handshakes.
// master drives operands and out_ready; slave is the ALU array.
interface alu_xor_array_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*WIDTH-1:0] a;
  logic [NCH*WIDTH-1:0] b;
  logic [NCH*3-1:0]     op;
  logic                 acc_clr;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH*WIDTH-1:0] result;
  logic [NCH-1:0]       carry;
  logic [NCH-1:0]       zero;
  logic [WIDTH-1:0]     xor_all;
  logic                 parity;

  modport master (
    output in_valid, a, b, op, acc_clr, out_ready,
    input  in_ready, out_valid, result, carry,
    input  zero, xor_all, parity
  );

  modport slave (
    input  in_valid, a, b, op, acc_clr, out_ready,
    output in_ready, out_valid, result, carry,
    output zero, xor_all, parity
  );
endinterface

// File: rtl/alu_xor_array.sv
// alu_xor_array: NCH pipelined ALU channels, accumulators, XOR reduce.
// Define ALU_SAT_EN for saturating ADD/SUB/ACC instead of wrap.
module alu_xor_array #(
  parameter int WIDTH = 8,
  parameter int NCH   = 2,
  parameter int PIPE  = 2
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n,
  alu_xor_array_if.slave bus
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_ACC  = 3'd5,
    OP_ACCX = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  logic advance;
  logic fire;
  logic out_valid_w;

  logic [NCH-1:0][WIDTH-1:0] alu_res;
  logic [NCH-1:0]            alu_cy;
  logic [NCH-1:0]            alu_zero;
  logic [NCH-1:0][WIDTH-1:0] acc_q;
  logic [NCH-1:0][WIDTH-1:0] acc_d;
  logic [NCH-1:0]            acc_we;

  logic                      s1_valid;
  logic [NCH-1:0][WIDTH-1:0] s1_res;
  logic [NCH-1:0]            s1_cy;
  logic [NCH-1:0]            s1_zero;
  logic [WIDTH-1:0]          s1_x;

  assign advance      = !out_valid_w | bus.out_ready;
  assign bus.in_ready = advance;
  assign fire         = bus.in_valid & advance;

  always_comb begin
    logic [WIDTH-1:0] a_k;
    logic [WIDTH-1:0] b_k;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   sum;
    logic             cy;
    op_e              op_k;
    alu_res  = '0;
    alu_cy   = '0;
    alu_zero = '0;
    acc_d    = acc_q;
    acc_we   = '0;
    a_k  = '0;
    b_k  = '0;
    base = '0;
    res  = '0;
    sum  = '0;
    cy   = 1'b0;
    op_k = OP_ADD;
    for (int k = 0; k < NCH; k++) begin
      a_k  = bus.a[k*WIDTH +: WIDTH];
      b_k  = bus.b[k*WIDTH +: WIDTH];
      op_k = op_e'(bus.op[k*3 +: 3]);
      // A coincident clear makes the op see an empty accumulator.
      base = bus.acc_clr ? '0 : acc_q[k];
      sum  = '0;
      res  = '0;
      cy   = 1'b0;
      unique case (op_k)
        OP_ADD: begin
          sum = {1'b0, a_k} + {1'b0, b_k};
          cy  = sum[WIDTH];
          res = sum[WIDTH-1:0];
        end
        OP_SUB: begin
          sum = {1'b0, a_k} - {1'b0, b_k};
          cy  = sum[WIDTH];
          res = sum[WIDTH-1:0];
        end
        OP_AND: res = a_k & b_k;
        OP_OR:  res = a_k | b_k;
        OP_XOR: res = a_k ^ b_k;
        OP_ACC: begin
          sum       = {1'b0, base} + {1'b0, a_k};
          cy        = sum[WIDTH];
          res       = sum[WIDTH-1:0];
          acc_we[k] = fire;
        end
        OP_ACCX: begin
          res       = base ^ a_k;
          acc_we[k] = fire;
        end
        OP_PASS: res = a_k;
      endcase
`ifdef ALU_SAT_EN
      if (cy) res = (op_k == OP_SUB) ? '0 : '1;
`endif
      alu_res[k]  = res;
      alu_cy[k]   = cy;
      alu_zero[k] = (res == '0);
      acc_d[k]    = res;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      acc_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (acc_we[k])        acc_q[k] <= acc_d[k];
        else if (bus.acc_clr) acc_q[k] <= '0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      s1_valid <= 1'b0;
      s1_res   <= '0;
      s1_cy    <= '0;
      s1_zero  <= '0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      s1_res   <= alu_res;
      s1_cy    <= alu_cy;
      s1_zero  <= alu_zero;
    end
  end

  always_comb begin
    s1_x = '0;
    for (int k = 0; k < NCH; k++) s1_x = s1_x ^ s1_res[k];
  end

  if (PIPE >= 2) begin : g_pipe2
    logic                      s2_valid;
    logic [NCH-1:0][WIDTH-1:0] s2_res;
    logic [NCH-1:0]            s2_cy;
    logic [NCH-1:0]            s2_zero;
    logic [WIDTH-1:0]          s2_x;
    logic                      s2_par;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
        s2_valid <= 1'b0;
        s2_res   <= '0;
        s2_cy    <= '0;
        s2_zero  <= '0;
        s2_x     <= '0;
        s2_par   <= 1'b0;
      end else if (advance) begin
        s2_valid <= s1_valid;
        s2_res   <= s1_res;
        s2_cy    <= s1_cy;
        s2_zero  <= s1_zero;
        s2_x     <= s1_x;
        s2_par   <= ^s1_x;
      end
    end

    assign out_valid_w = s2_valid;
    assign bus.result  = s2_res;
    assign bus.carry   = s2_cy;
    assign bus.zero    = s2_zero;
    assign bus.xor_all = s2_x;
    assign bus.parity  = s2_par;
  end else begin : g_pipe1
    assign out_valid_w = s1_valid;
    assign bus.result  = s1_res;
    assign bus.carry   = s1_cy;
    assign bus.zero    = s1_zero;
    assign bus.xor_all = s1_x;
    assign bus.parity  = ^s1_x;
  end

  assign bus.out_valid = out_valid_w;

endmodule

// File: tb/tb_alu_xor_array.sv
// tb_alu_xor_array: directed vector table plus stall/reset sequences.
// Build with +define+ALU_SAT_EN to check the saturating variant.
module tb_alu_xor_array;

  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] SUB  = 3'd1;
  localparam logic [2:0] AND_ = 3'd2;
  localparam logic [2:0] OR_  = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4;
  localparam logic [2:0] ACC  = 3'd5;
  localparam logic [2:0] ACCX = 3'd6;
  localparam logic [2:0] PASS = 3'd7;

  typedef struct {
    logic [2:0] o0;
    logic [7:0] a0;
    logic [7:0] b0;
    logic [2:0] o1;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       clr;
    logic [7:0] r0;
    logic [7:0] r1;
    logic [1:0] cy;
    logic [1:0] z;
    logic [7:0] x;
    logic       p;
  } vec_t;

  logic wb_clk_i = 1'b0;
  logic wb_rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_xor_array_if #(.WIDTH(8), .NCH(2)) bus0 ();
  alu_xor_array_if #(.WIDTH(8), .NCH(2)) bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.a         = bus0.a;
  assign bus1.b         = bus0.b;
  assign bus1.op        = bus0.op;
  assign bus1.acc_clr   = bus0.acc_clr;
  assign bus1.out_ready = bus0.out_ready;

  alu_xor_array #(.WIDTH(8), .NCH(2), .PIPE(2)) u_dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_n (wb_rst_n),
    .bus      (bus0.slave)
  );

  alu_xor_array #(.WIDTH(8), .NCH(2), .PIPE(1)) u_dut1 (
    .wb_clk_i (wb_clk_i),
    .wb_rst_n (wb_rst_n),
    .bus      (bus1.slave)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic step;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o0,
                       input logic [7:0] a0, b0,
                       input logic [2:0] o1,
                       input logic [7:0] a1, b1,
                       input logic clr);
    bus0.in_valid = 1'b1;
    bus0.a        = {a1, a0};
    bus0.b        = {b1, b0};
    bus0.op       = {o1, o0};
    bus0.acc_clr  = clr;
  endtask

  task automatic idle;
    bus0.in_valid = 1'b0;
    bus0.acc_clr  = 1'b0;
  endtask

  function automatic vec_t mk(
    input logic [2:0] o0, input logic [7:0] a0, b0,
    input logic [2:0] o1, input logic [7:0] a1, b1,
    input logic clr,
    input logic [7:0] r0, r1,
    input logic [1:0] cy, z,
    input logic [7:0] x, input logic p);
    vec_t v;
    v.o0 = o0; v.a0 = a0; v.b0 = b0;
    v.o1 = o1; v.a1 = a1; v.b1 = b1;
    v.clr = clr;
    v.r0 = r0; v.r1 = r1;
    v.cy = cy; v.z = z;
    v.x = x; v.p = p;
    return v;
  endfunction

  vec_t tbl [10];

  initial begin
    logic [7:0] sub_exp;
    logic [15:0] held;
    logic        stalled_prev;
    logic        fire;
    logic        took;
    int          sent;
    int          rx;

    bus0.in_valid  = 1'b0;
    bus0.a         = '0;
    bus0.b         = '0;
    bus0.op        = '0;
    bus0.acc_clr   = 1'b0;
    bus0.out_ready = 1'b1;

`ifdef ALU_SAT_EN
    tbl[0] = mk(ADD, 8'hFF, 8'h01, XOR_, 8'hA5, 8'h5A, 0,
                8'hFF, 8'hFF, 2'b01, 2'b00, 8'h00, 0);
    tbl[1] = mk(SUB, 8'h10, 8'h20, AND_, 8'hF0, 8'h3C, 0,
                8'h00, 8'h30, 2'b01, 2'b01, 8'h30, 0);
    tbl[5] = mk(ACC, 8'h40, 8'h00, ACCX, 8'h0F, 8'h00, 0,
                8'hFF, 8'h3C, 2'b01, 2'b00, 8'hC3, 0);
    tbl[9] = mk(ACC, 8'h80, 8'h00, ADD, 8'h80, 8'h80, 0,
                8'hFF, 8'hFF, 2'b11, 2'b00, 8'h00, 0);
    sub_exp = 8'h00;
`else
    tbl[0] = mk(ADD, 8'hFF, 8'h01, XOR_, 8'hA5, 8'h5A, 0,
                8'h00, 8'hFF, 2'b01, 2'b01, 8'hFF, 0);
    tbl[1] = mk(SUB, 8'h10, 8'h20, AND_, 8'hF0, 8'h3C, 0,
                8'hF0, 8'h30, 2'b01, 2'b00, 8'hC0, 0);
    tbl[5] = mk(ACC, 8'h40, 8'h00, ACCX, 8'h0F, 8'h00, 0,
                8'h00, 8'h3C, 2'b01, 2'b01, 8'h3C, 0);
    tbl[9] = mk(ACC, 8'h80, 8'h00, ADD, 8'h80, 8'h80, 0,
                8'h00, 8'h00, 2'b11, 2'b11, 8'h00, 0);
    sub_exp = 8'hF0;
`endif
    tbl[2] = mk(ACC, 8'h40, 8'h00, OR_, 8'h0F, 8'hF0, 0,
                8'h40, 8'hFF, 2'b00, 2'b00, 8'hBF, 1);
    tbl[3] = mk(ACC, 8'h40, 8'h00, PASS, 8'h00, 8'h00, 0,
                8'h80, 8'h00, 2'b00, 2'b10, 8'h80, 1);
    tbl[4] = mk(ACC, 8'h40, 8'h00, ACCX, 8'h33, 8'h00, 0,
                8'hC0, 8'h33, 2'b00, 2'b00, 8'hF3, 0);
    tbl[6] = mk(ACC, 8'h05, 8'h00, ACCX, 8'h11, 8'h00, 1,
                8'h05, 8'h11, 2'b00, 2'b00, 8'h14, 0);
    tbl[7] = mk(ACC, 8'h05, 8'h00, SUB, 8'h05, 8'h05, 0,
                8'h0A, 8'h00, 2'b00, 2'b10, 8'h0A, 0);
    tbl[8] = mk(ACC, 8'h80, 8'h00, ADD, 8'h7F, 8'h01, 1,
                8'h80, 8'h80, 2'b00, 2'b00, 8'h00, 0);

    // Reset state
    #2;
    chk("rst_out_valid", 32'(bus0.out_valid), 0);
    chk("rst_result", 32'(bus0.result), 0);
    chk("rst_flags", 32'({bus0.carry, bus0.zero, bus0.parity}), 0);
    chk("rst_xor_all", 32'(bus0.xor_all), 0);
    chk("rst_p1_valid", 32'(bus1.out_valid), 0);
    step;
    wb_rst_n = 1'b1;
    step;
    chk("idle_in_ready", 32'(bus0.in_ready), 1);

    // SUB borrow: PIPE=1 after one cycle, PIPE=2 after two
    drive(SUB, 8'h10, 8'h20, PASS, 8'h00, 8'h00, 0);
    step;
    idle;
    chk("p1_sub_valid", 32'(bus1.out_valid), 1);
    chk("p1_sub_res", 32'(bus1.result[7:0]), 32'(sub_exp));
    chk("p1_sub_carry", 32'(bus1.carry[0]), 1);
    chk("p2_sub_early", 32'(bus0.out_valid), 0);
    step;
    chk("p2_sub_valid", 32'(bus0.out_valid), 1);
    chk("p2_sub_res", 32'(bus0.result[7:0]), 32'(sub_exp));
    chk("p2_sub_carry", 32'(bus0.carry[0]), 1);
    chk("p1_sub_drain", 32'(bus1.out_valid), 0);
    step;

    // Back-to-back vector table, outputs two cycles behind
    for (int i = 0; i <= 10; i++) begin
      if (i < 10)
        drive(tbl[i].o0, tbl[i].a0, tbl[i].b0,
              tbl[i].o1, tbl[i].a1, tbl[i].b1, tbl[i].clr);
      else
        idle;
      step;
      if (i >= 1) begin
        chk($sformatf("v%0d_valid", i-1),
            32'(bus0.out_valid), 1);
        chk($sformatf("v%0d_result", i-1), 32'(bus0.result),
            32'({tbl[i-1].r1, tbl[i-1].r0}));
        chk($sformatf("v%0d_carry", i-1),
            32'(bus0.carry), 32'(tbl[i-1].cy));
        chk($sformatf("v%0d_zero", i-1),
            32'(bus0.zero), 32'(tbl[i-1].z));
        chk($sformatf("v%0d_xor", i-1),
            32'(bus0.xor_all), 32'(tbl[i-1].x));
        chk($sformatf("v%0d_parity", i-1),
            32'(bus0.parity), 32'(tbl[i-1].p));
      end
    end
    step;
    chk("drain_valid", 32'(bus0.out_valid), 0);

    // Backpressure: five PASS transfers, out_ready low 3 cycles
    sent = 0;
    rx = 0;
    held = '0;
    stalled_prev = 1'b0;
    for (int cyc = 0; cyc < 40 && rx < 5; cyc++) begin
      if (sent < 5)
        drive(PASS, 8'h01 + 8'(sent), 8'h00,
              PASS, 8'h10 + 8'(sent), 8'h00, 0);
      else
        idle;
      bus0.out_ready = !(cyc >= 3 && cyc < 6);
      #1;
      if (bus0.out_valid && !bus0.out_ready)
        chk("bp_in_ready", 32'(bus0.in_ready), 0);
      if (stalled_prev)
        chk("bp_hold", 32'(bus0.result), 32'(held));
      fire = bus0.in_valid & bus0.in_ready;
      took = bus0.out_valid & bus0.out_ready;
      if (took) begin
        chk($sformatf("bp_res%0d", rx), 32'(bus0.result),
            32'({8'h10 + 8'(rx), 8'h01 + 8'(rx)}));
        rx++;
      end
      stalled_prev = bus0.out_valid & !bus0.out_ready;
      held = bus0.result;
      step;
      if (fire) sent++;
    end
    idle;
    bus0.out_ready = 1'b1;
    chk("bp_rx_count", 32'(rx), 5);
    chk("bp_tx_count", 32'(sent), 5);
    step;
    step;
    chk("bp_no_dup", 32'(bus0.out_valid), 0);

    // Reset with two transactions in flight
    drive(ACC, 8'h07, 8'h00, ACCX, 8'h55, 8'h00, 0);
    step;
    drive(ACC, 8'h01, 8'h00, ACCX, 8'h01, 8'h00, 0);
    step;
    idle;
    chk("pre_rst_valid", 32'(bus0.out_valid), 1);
    wb_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus0.out_valid), 0);
    chk("mid_rst_result", 32'(bus0.result), 0);
    chk("mid_rst_flags",
        32'({bus0.carry, bus0.zero, bus0.parity}), 0);
    chk("mid_rst_xor", 32'(bus0.xor_all), 0);
    step;
    wb_rst_n = 1'b1;
    step;
    chk("post_rst_valid", 32'(bus0.out_valid), 0);
    drive(ACC, 8'h03, 8'h00, ACCX, 8'h03, 8'h00, 0);
    step;
    idle;
    step;
    chk("post_rst_acc_valid", 32'(bus0.out_valid), 1);
    chk("post_rst_acc", 32'(bus0.result), 32'h0303);
    step;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
